// File: rtl/hybrid_bp.sv
// hybrid_bp: tournament branch predictor for the fetch stage.
//   A per-PC bimodal (local) table, a gshare (global) table indexed with
//   li ^ GHR, and a per-PC chooser, all built from CNT_W-bit saturating
//   counters. Prediction metadata travels through PIPE_DEPTH stall-aware
//   stages to the resolve point, where the tables, the non-speculative GHR
//   and the statistics counters are trained.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc              fetch address to predict
//   mode            0 tournament, 1 local, 2 global, 3 static not-taken
//   stall           stall[k] holds metadata stage k+1
//   update, br_en   a branch resolves this cycle with outcome br_en
//   br_take         combinational prediction for pc
//   mispred         resolving branch was mispredicted (combinational)
//   br_count        resolved branches (saturating)
//   mispred_count   mispredicted branches (saturating)
module hybrid_bp #(
  parameter int IDX_W      = 4,
  parameter int PC_OFFSET  = 2,
  parameter int HIST_W     = 4,
  parameter int CNT_W      = 2,
  parameter int PIPE_DEPTH = 2,
  parameter int STAT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  input  logic [1:0]            mode,
  input  logic [PIPE_DEPTH-1:0] stall,
  input  logic                  update,
  input  logic                  br_en,
  output logic                  br_take,
  output logic                  mispred,
  output logic [STAT_W-1:0]     br_count,
  output logic [STAT_W-1:0]     mispred_count
);

  localparam int ROWS = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [31:0] IDX_MASK = 32'((ROWS - 1) << PC_OFFSET);

  typedef struct packed {
    logic [IDX_W-1:0] li;
    logic [IDX_W-1:0] gi;
    logic             l_pred;
    logic             g_pred;
    logic             f_pred;
  } meta_t;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic up);
    if (up) return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    else    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
    return (s == {STAT_W{1'b1}}) ? s : s + STAT_W'(1);
  endfunction

  logic [CNT_W-1:0]  loc_tab [ROWS];
  logic [CNT_W-1:0]  glb_tab [ROWS];
  logic [CNT_W-1:0]  cho_tab [ROWS];
  logic [HIST_W-1:0] ghr;
  meta_t             meta_p [PIPE_DEPTH];

  // Resolve side: last metadata stage drives training
  meta_t             res;
  logic [CNT_W-1:0]  loc_new;
  logic [CNT_W-1:0]  glb_new;
  logic [CNT_W-1:0]  cho_new;
  logic              cho_wr;
  logic [HIST_W:0]   hist_cat;
  logic [HIST_W-1:0] ghr_shift;
  logic [HIST_W-1:0] ghr_nxt;

  assign res      = meta_p[PIPE_DEPTH-1];
  assign loc_new  = cnt_step(loc_tab[res.li], br_en);
  assign glb_new  = cnt_step(glb_tab[res.gi], br_en);
  // Components disagree, so exactly one was wrong; move toward the right one.
  assign cho_wr   = update && (res.l_pred != res.g_pred);
  assign cho_new  = cnt_step(cho_tab[res.li], res.l_pred != br_en);
  // Concatenate then drop the oldest bit; works for HIST_W == 1 as well.
  assign hist_cat  = {ghr, br_en};
  assign ghr_shift = hist_cat[HIST_W-1:0];
  assign ghr_nxt   = update ? ghr_shift : ghr;
  assign mispred   = update && (res.f_pred != br_en);

  // Lookup side: reads see this cycle's update through forwarding
  logic [IDX_W-1:0] li;
  logic [IDX_W-1:0] gi;
  logic [CNT_W-1:0] loc_rd;
  logic [CNT_W-1:0] glb_rd;
  logic [CNT_W-1:0] cho_rd;
  logic             f_pred;
  meta_t            cur;
  logic             misc_unused;

  assign li     = pc[IDX_W+PC_OFFSET-1:PC_OFFSET];
  assign gi     = li ^ IDX_W'(ghr_nxt);
  assign loc_rd = (update && res.li == li) ? loc_new : loc_tab[li];
  assign glb_rd = (update && res.gi == gi) ? glb_new : glb_tab[gi];
  assign cho_rd = (cho_wr && res.li == li) ? cho_new : cho_tab[li];

  always_comb begin
    f_pred = 1'b0;
    case (mode)
      2'd0:    f_pred = cho_rd[CNT_W-1] ? glb_rd[CNT_W-1] : loc_rd[CNT_W-1];
      2'd1:    f_pred = loc_rd[CNT_W-1];
      2'd2:    f_pred = glb_rd[CNT_W-1];
      default: f_pred = 1'b0;
    endcase
  end

  assign br_take     = f_pred;
  assign cur         = '{li: li, gi: gi, l_pred: loc_rd[CNT_W-1],
                         g_pred: glb_rd[CNT_W-1], f_pred: f_pred};
  assign misc_unused = ^{pc & ~IDX_MASK, hist_cat[HIST_W]};

  // Training state: tables, GHR and statistics land at the update edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        loc_tab[r] <= CNT_INIT;
        glb_tab[r] <= CNT_INIT;
        cho_tab[r] <= CNT_INIT;
      end
      ghr           <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else if (update) begin
      loc_tab[res.li] <= loc_new;
      glb_tab[res.gi] <= glb_new;
      if (cho_wr) cho_tab[res.li] <= cho_new;
      ghr      <= ghr_shift;
      br_count <= stat_inc(br_count);
      if (mispred) mispred_count <= stat_inc(mispred_count);
    end
  end

  // Metadata stages: a stalled stage holds; the stage after it may duplicate
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) meta_p[k] <= '0;
    end else begin
      if (!stall[0]) meta_p[0] <= cur;
      for (int k = 1; k < PIPE_DEPTH; k++)
        if (!stall[k]) meta_p[k] <= meta_p[k-1];
    end
  end

endmodule

// File: tb/tb_hybrid_bp.sv
module tb_hybrid_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [1:0]  mode;
  logic [1:0]  stall;
  logic        update;
  logic        br_en;
  logic        br_take;
  logic        mispred;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  logic        rst2;
  logic [31:0] pc2;
  logic [1:0]  mode2;
  logic [1:0]  stall2;
  logic        update2;
  logic        br_en2;
  logic        take2;
  logic        mis2;
  logic [2:0]  brc2;
  logic [2:0]  misc2;

  always #5 clk = ~clk;

  hybrid_bp dut (
    .clk(clk), .rst(rst), .pc(pc), .mode(mode), .stall(stall),
    .update(update), .br_en(br_en), .br_take(br_take), .mispred(mispred),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  hybrid_bp #(.STAT_W(3)) dut_s3 (
    .clk(clk), .rst(rst2), .pc(pc2), .mode(mode2), .stall(stall2),
    .update(update2), .br_en(br_en2), .br_take(take2), .mispred(mis2),
    .br_count(brc2), .mispred_count(misc2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int li;
    int gi;
    bit lp;
    bit gp;
    bit fp;
  } rec_t;

  rec_t sb[$];
  int   m_loc [16];
  int   m_glb [16];
  int   m_cho [16];
  int   m_ghr;
  int   exp_br;
  int   exp_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t model_predict(input logic [31:0] a, input logic [1:0] m);
    rec_t r;
    r.li = int'((a >> 2) & 32'hF);
    r.gi = r.li ^ m_ghr;
    r.lp = (m_loc[r.li] >= 2);
    r.gp = (m_glb[r.gi] >= 2);
    case (m)
      2'd0:    r.fp = (m_cho[r.li] >= 2) ? r.gp : r.lp;
      2'd1:    r.fp = r.lp;
      2'd2:    r.fp = r.gp;
      default: r.fp = 1'b0;
    endcase
    return r;
  endfunction

  task automatic model_update(input rec_t r, input bit o);
    if (o) begin
      if (m_loc[r.li] < 3) m_loc[r.li]++;
      if (m_glb[r.gi] < 3) m_glb[r.gi]++;
    end else begin
      if (m_loc[r.li] > 0) m_loc[r.li]--;
      if (m_glb[r.gi] > 0) m_glb[r.gi]--;
    end
    if (r.lp != r.gp) begin
      if (r.lp != o) begin
        if (m_cho[r.li] < 3) m_cho[r.li]++;
      end else begin
        if (m_cho[r.li] > 0) m_cho[r.li]--;
      end
    end
    m_ghr = ((m_ghr << 1) | int'(o)) & 15;
    exp_br++;
    if (r.fp != o) exp_mis++;
  endtask

  task automatic do_reset();
    rst = 1'b1; update = 1'b0; br_en = 1'b0; stall = 2'b00; pc = 32'h0; mode = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_loc[i] = 1; m_glb[i] = 1; m_cho[i] = 1;
    end
    m_ghr = 0; exp_br = 0; exp_mis = 0;
    sb.delete();
  endtask

  // Predict at a, let the record reach the last stage, then resolve with o.
  task automatic resolve(input logic [31:0] a, input logic [1:0] m, input bit o,
                         output logic got_mis, output logic got_fwd);
    rec_t r;
    rec_t rn;
    pc = a; mode = m; update = 1'b0; stall = 2'b00;
    r = model_predict(a, m);
    #4;
    chk("predict_take", 32'(br_take), 32'(r.fp));
    chk("idle_mispred", 32'(mispred), 32'h0);
    sb.push_back(r);
    @(posedge clk); #1;
    @(posedge clk); #1;
    update = 1'b1; br_en = o;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'h1, 32'h0);
      r = model_predict(a, m);
    end else begin
      r = sb.pop_front();
    end
    model_update(r, o);
    rn = model_predict(a, m);
    #4;
    got_mis = mispred;
    got_fwd = br_take;
    chk("resolve_mispred", 32'(mispred), 32'(r.fp != o));
    chk("forwarded_take", 32'(br_take), 32'(rn.fp));
    @(posedge clk); #1;
    update = 1'b0;
    chk("br_count", br_count, 32'(exp_br));
    chk("mispred_count", mispred_count, 32'(exp_mis));
  endtask

  initial begin
    logic gm;
    logic gf;
    rec_t r;

    rst2 = 1'b1; pc2 = 32'h0; mode2 = 2'd3; stall2 = 2'b00; update2 = 1'b0; br_en2 = 1'b1;

    // Reset state, with an update held during reset that must be ignored
    rst = 1'b1; update = 1'b1; br_en = 1'b1; stall = 2'b00; pc = 32'h100; mode = 2'd1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; update = 1'b0;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      #4;
      chk("reset_take", 32'(br_take), 32'h0);
      chk("reset_mispred", 32'(mispred), 32'h0);
      chk("reset_br_count", br_count, 32'h0);
      chk("reset_mispred_count", mispred_count, 32'h0);
      @(posedge clk); #1;
    end

    // Local learning
    do_reset();
    resolve(32'h40, 2'd1, 1'b1, gm, gf);
    chk("local_first_mispred", 32'(gm), 32'h1);
    resolve(32'h40, 2'd1, 1'b1, gm, gf);
    chk("local_second_mispred", 32'(gm), 32'h0);
    pc = 32'h40; mode = 2'd1;
    #4;
    chk("local_learned_take", 32'(br_take), 32'h1);
    chk("local_br_count", br_count, 32'd2);
    chk("local_mispred_count", mispred_count, 32'd1);
    @(posedge clk); #1;

    // Forwarding: update of row 5 and lookup of row 5 in the same cycle
    do_reset();
    resolve(32'h14, 2'd1, 1'b1, gm, gf);
    chk("forward_same_cycle", 32'(gf), 32'h1);

    // Tournament convergence on alternating outcomes
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      resolve(32'h80, 2'd2, bit'(k % 2), gm, gf);
      if (k > 8) chk("global_converged", 32'(gm), 32'h0);
    end
    do_reset();
    for (int k = 1; k <= 16; k++) resolve(32'h80, 2'd1, bit'(k % 2), gm, gf);
    chk("local_alt_mispred_count", mispred_count, 32'd16);
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      resolve(32'h80, 2'd0, bit'(k % 2), gm, gf);
      if (k == 16) chk("tournament_converged", 32'(gm), 32'h0);
    end
    pc = 32'h80; mode = 2'd0;
    r = model_predict(32'h80, 2'd0);
    #4;
    chk("tournament_picks_global", 32'(br_take), 32'(r.gp));
    @(posedge clk); #1;

    // Stall hold: record captured at 0x40 must survive three stalled cycles
    do_reset();
    pc = 32'h40; mode = 2'd1;
    sb.push_back(model_predict(32'h40, 2'd1));
    @(posedge clk); #1;
    stall = 2'b01; pc = 32'h44;
    @(posedge clk); #1;
    pc = 32'h48;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 2'b00; update = 1'b1; br_en = 1'b1;
    r = sb.pop_front();
    model_update(r, 1'b1);
    #4;
    chk("stall_mispred", 32'(mispred), 32'h1);
    @(posedge clk); #1;
    update = 1'b0;
    pc = 32'h44; #4; chk("stall_row1_unchanged", 32'(br_take), 32'h0);
    @(posedge clk); #1;
    pc = 32'h48; #4; chk("stall_row2_unchanged", 32'(br_take), 32'h0);
    @(posedge clk); #1;
    pc = 32'h40; #4; chk("stall_row0_trained", 32'(br_take), 32'h1);
    chk("stall_br_count", br_count, 32'd1);
    @(posedge clk); #1;

    // Static mode
    do_reset();
    for (int k = 0; k < 5; k++) begin
      resolve(32'h100 + 32'(4 * k), 2'd3, 1'b1, gm, gf);
      chk("static_mispred", 32'(gm), 32'h1);
    end
    chk("static_br_count", br_count, 32'd5);
    chk("static_mispred_count", mispred_count, 32'd5);

    // Statistics saturation with STAT_W = 3
    @(posedge clk); #1;
    rst2 = 1'b0;
    #4;
    chk("s3_reset_count", 32'(brc2), 32'h0);
    @(posedge clk); #1;
    update2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      #4;
      chk("s3_mispred", 32'(mis2), 32'h1);
      @(posedge clk); #1;
      chk("s3_br_count", 32'(brc2), 32'((k > 7) ? 7 : k));
      chk("s3_mispred_count", 32'(misc2), 32'((k > 7) ? 7 : k));
    end
    update2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hybrid_bp.md
# hybrid_bp

Parametrised tournament branch predictor for the fetch stage, the successor to the fixed-width local/global chooser. It combines a per-PC bimodal table, a gshare table indexed with a global history register (GHR), and a per-PC chooser, all with configurable counter width. Prediction metadata is carried through a configurable number of stall-aware pipeline stages to the resolve stage. The mode is selectable at run time, and the block keeps branch and mispredict statistics counters.

## Interface
- IDX_W, 4, index bits of each table (2^IDX_W rows per table)
- PC_OFFSET, 2, lowest PC bit used for indexing
- HIST_W, 4, GHR length; legal range 1..IDX_W
- CNT_W, 2, saturating counter width for all tables; CNT_W >= 2
- PIPE_DEPTH, 2, metadata stages from predict to resolve; PIPE_DEPTH >= 1
- STAT_W, 32, width of the statistics counters
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- pc  in  32  fetch address for the current prediction
- mode  in  2  0 tournament, 1 local only, 2 global only, 3 static not-taken
- stall  in  PIPE_DEPTH  stall[k] holds metadata stage k+1
- update  in  1  a branch resolves this cycle, using the last metadata stage
- br_en  in  1  actual outcome of the resolving branch
- br_take  out  1  prediction for pc (combinational)
- mispred  out  1  update && (stored final prediction != br_en)
- br_count  out  STAT_W  number of resolved branches
- mispred_count  out  STAT_W  number of mispredictions

## Operation
- **Indexing**
  - Local and chooser index: li = pc[IDX_W+PC_OFFSET-1:PC_OFFSET].
  - Global index: gi = li XOR zero-extended GHR.
- **Component predictions**
  - A counter predicts taken when its MSB = 1.
  - The chooser selects global when its MSB = 1.
- **Final prediction by mode**
  - Mode 0: chooser pick.
  - Mode 1: local.
  - Mode 2: global.
  - Mode 3: 0.
  - br_take = final prediction.
- **Metadata record**
  - Captured at predict: {li, gi, l_pred, g_pred, final_pred}.
  - Stage 1 loads the record unless stall[0]. Stage k loads from stage k-1 unless stall[k-1].
  - Resolve always uses stage PIPE_DEPTH.
- **On update**
  - Local[li] and global[gi] move one step toward br_en, saturating at 0 and 2^CNT_W-1. Both tables train in every mode.
  - Chooser[li] changes only when l_pred != g_pred (exactly one component wrong):
    - +1 toward global if local was wrong, saturating;
    - -1 if global was wrong, saturating at 0.
  - GHR <= {GHR[HIST_W-2:0], br_en}. The GHR is non-speculative and shifts only on update.
  - br_count increments, saturating at all-ones.
  - mispred_count increments when mispred = 1, saturating at all-ones.
- **Forwarding**
  - Lookups in the same cycle as an update use post-update values: written counter values where indices match, and the next GHR value for gi.
- **Reset values**
  - All counters (local, global, chooser): 2^(CNT_W-1)-1, i.e. weakly not-taken / weakly local.
  - GHR: 0.
  - Metadata stages: all zero.
  - Statistics counters: 0.
  - Outputs after reset: br_take = 0, mispred = 0, counts = 0.
- **Reset priority and stalls**
  - rst overrides update in the same cycle.
  - A stalled stage never drops its record.
  - If a stage is stalled while the next is not, the next stage receives a duplicate record. The pipeline must not assert update twice for one branch.
- A change of mode affects the next lookup only. Training is unaffected.

## Timing
- Prediction latency: 0 cycles. br_take is combinational from pc, mode, the table state and the forwarded update.
- Resolve: mispred is combinational in the update cycle.
- Table, GHR and count writes land at the update posedge and are visible in the next cycle.
- Record latency: the record captured at the posedge ending cycle t is available for resolve in cycle t+PIPE_DEPTH, plus one cycle per stall hold.
- Simultaneous update and lookup at the same row: the forwarded (new) value wins.

## Test plan
- **Reset state**
  - Stimulus: assert rst for 2 cycles, then pc = 0x100 with each mode 0..3.
  - Required: br_take = 0, mispred = 0, br_count = mispred_count = 0.
- **Local learning**
  - Stimulus: mode 1, pc = 0x40 (li = 0). Resolve br_en = 1 twice.
  - Required: first resolve mispred = 1. Local[0] goes 1→2→3. A later lookup of 0x40 gives br_take = 1. br_count = 2, mispred_count = 1.
- **Forwarding**
  - Stimulus: local[5] = 1. In one cycle, resolve a record with li = 5 and br_en = 1, while pc = 0x14 (li = 5) in mode 1.
  - Required: br_take = 1 in that same cycle.
- **Tournament convergence**
  - Stimulus: a single pc with alternating T,N,T,N,…; resolve 16 outcomes.
  - Required:
    - Mode 2: mispred = 0 after 8 resolves.
    - Mode 1: mispredicts persist.
    - Mode 0: chooser MSB = 1 and mispred = 0 by resolve 16.
- **Stall hold**
  - Stimulus: PIPE_DEPTH = 2. Hold stall[0] for 3 cycles while pc changes 0x40→0x44→0x48, then release and resolve.
  - Required: the update uses li = 0, captured at 0x40 just before the stall. Rows 1 and 2 are unchanged.
- **Static mode and saturation**
  - Stimulus: mode 3, 5 updates with br_en = 1. Then STAT_W = 3 with 9 updates.
  - Required: mode 3 gives br_take = 0, mispred = 1 on every update, both counts = 5. With STAT_W = 3, br_count holds at 7.
